mips_mc_controller: RTL and testbench

//  Multi-cycle control FSM for the MIPS core. Sequences fetch, decode, execute, memory and writeback around the instruction parser.

---
 rtl/mips_pkg.sv | 100 ++++++++++
 rtl/mips_mem_timer.sv | 33 +++
 rtl/mips_mc_controller.sv | 171 +++++++++++++++++
 tb/tb_mips_mc_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// datapath select codes and the controller state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_LUI   = 3'd6;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_BRANCH   = 4'd6,
    S_JUMP     = 4'd7,
    S_JR       = 4'd8,
    S_MEM_ADDR = 4'd9,
    S_MEM_RD   = 4'd10,
    S_MEM_WR   = 4'd11,
    S_MEM_WB   = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  // Where DECODE goes for a given instruction; unsupported encodings trap.
  function automatic state_e decode_target(input logic [5:0] op, input logic [5:0] fn);
    state_e s;
    s = S_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_JR)
          s = S_JR;
        else if (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
          s = S_EXEC_R;
      end
      OP_J, OP_JAL:                                s = S_JUMP;
      OP_BEQ, OP_BNE:                              s = S_BRANCH;
      OP_LW, OP_SW:                                s = S_MEM_ADDR;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:   s = S_EXEC_I;
      default:                                     s = S_ILLEGAL;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] a;
    case (op)
      OP_SLTI: a = ALU_SLT;
      OP_ANDI: a = ALU_AND;
      OP_ORI:  a = ALU_OR;
      OP_LUI:  a = ALU_LUI;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mips_mem_timer.sv
// Bus-access wait counter: counts waiting cycles of one access and flags
// when the configured limit is reached (limit 0 never expires).
module mips_mem_timer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (clr)
      cnt_reg <= '0;
    else if (en)
      cnt_reg <= cnt_reg + 1'b1;
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = (cnt_reg == TO_W'(TIMEOUT_CYC));
    end
  endgenerate

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath strobes, times out bus accesses, counts retires.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        illegal_op,
  output logic        bus_err,
  output logic [3:0]  state_o,
  output logic [31:0] retired
);

  state_e      state_reg, state_next;
  logic [31:0] retired_reg;
  logic        in_mem, expired, timeout_fire, retire;

  assign in_mem       = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) || (state_reg == S_MEM_WR);
  // A ready arriving on the expiry cycle still completes the access.
  assign timeout_fire = in_mem && expired && !mem_ready;

  // Cleared outside memory states so every access starts counting from zero.
  mips_mem_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!in_mem || mem_ready || timeout_fire),
    .en     (in_mem && !mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= S_FETCH;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE:   state_next = decode_target(opcode, funct);
      S_EXEC_R:   state_next = S_WB_R;
      S_EXEC_I:   state_next = S_WB_I;
      S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)
          state_next = S_MEM_WB;
        else if (timeout_fire)
          state_next = S_FETCH;
      end
      S_MEM_WR:   if (mem_ready || timeout_fire) state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    wb_sel     = WB_ALUOUT;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    if (rst_n) begin
      bus_err = timeout_fire;
      case (state_reg)
        S_FETCH: begin
          mem_req   = !timeout_fire;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRCB_IMM_SH;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = DST_RD;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = imm_alu_op(opcode);
        end
        S_WB_I: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = PC_ALUOUT;
          pc_write  = (opcode == OP_BEQ) ? zero : !zero;
        end
        S_JUMP: begin
          pc_src   = PC_JUMP;
          pc_write = 1'b1;
          if (opcode == OP_JAL) begin
            reg_write = 1'b1;
            reg_dst   = DST_RA;
            wb_sel    = WB_PC;
          end
        end
        S_JR: begin
          pc_src   = PC_RS;
          pc_write = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD, S_MEM_WR: begin
          mem_req = !timeout_fire;
          iord    = 1'b1;
          mem_we  = (state_reg == S_MEM_WR);
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
        end
        S_ILLEGAL: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

  assign retire = (state_reg == S_WB_R)   || (state_reg == S_WB_I) ||
                  (state_reg == S_MEM_WB) || (state_reg == S_BRANCH) ||
                  (state_reg == S_JUMP)   || (state_reg == S_JR) ||
                  ((state_reg == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired_reg <= '0;
    else if (retire)
      retired_reg <= retired_reg + 32'd1;
  end

  assign retired = retired_reg;
  assign state_o = state_reg;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed scenarios plus random
// instructions checked against a per-instruction-class behavioural model.
module tb_mips_mc_controller;

  localparam int TO    = 4;
  localparam int NEVER = 99;

  localparam int C_R = 0, C_I = 1, C_BR = 2, C_J = 3, C_JAL = 4, C_JR = 5,
                 C_LW = 6, C_SW = 7, C_ILL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h0, funct = 6'h0;
  logic        zero = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]  pc_src, alu_src_b, reg_dst, wb_sel;
  logic        alu_src_a, reg_write, illegal_op, bus_err;
  logic [2:0]  alu_op;
  logic [3:0]  state_o;
  logic [31:0] retired;

  mips_mc_controller #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .illegal_op(illegal_op), .bus_err(bus_err), .state_o(state_o),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [31:0] exp_retired = 32'd0;

  // Per-instruction observations
  int o_cyc, o_memreq, o_irw, o_pcw, o_regw, o_ill, o_berr, o_we;
  logic [1:0] o_pc_src, o_reg_dst, o_wb_sel, o_exec_srcb, o_dec_srcb;
  logic [2:0] o_exec_alu_op;
  bit o_hang;

  // Runs one instruction from FETCH back to FETCH; wf/wm = wait cycles for
  // the fetch and data access (NEVER = memory never answers).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm);
    int waited, acc, irw_idx, target;
    bit seen;
    opcode = op; funct = fn; zero = z;
    o_cyc = 0; o_memreq = 0; o_irw = 0; o_pcw = 0; o_regw = 0; o_ill = 0; o_berr = 0; o_we = 0;
    o_pc_src = 2'bx; o_reg_dst = 2'bx; o_wb_sel = 2'bx; o_exec_srcb = 2'bx; o_dec_srcb = 2'bx;
    o_exec_alu_op = 3'bx; o_hang = 0;
    waited = 0; acc = 0; irw_idx = -10; seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (state_o != 4'd0) seen = 1;
      if (mem_req) begin
        target = (acc == 0) ? wf : wm;
        if (waited >= target) begin
          mem_ready = 1'b1; waited = 0; acc++;
        end else begin
          waited++;
        end
      end
      #1;
      o_cyc++;
      if (mem_req) o_memreq++;
      if (mem_req && mem_we) o_we++;
      if (ir_write) begin o_irw++; irw_idx = o_cyc; end
      if (pc_write) begin o_pcw++; o_pc_src = pc_src; end
      if (reg_write) begin o_regw++; o_reg_dst = reg_dst; o_wb_sel = wb_sel; end
      if (illegal_op) o_ill++;
      if (bus_err) o_berr++;
      if (o_cyc == irw_idx + 1) o_dec_srcb = alu_src_b;
      if (o_cyc == irw_idx + 2) begin o_exec_alu_op = alu_op; o_exec_srcb = alu_src_b; end
      @(posedge clk);
      #1;
      if (state_o == 4'd0 && seen) begin
        mem_ready = 1'b0;
        return;
      end
    end
    o_hang = 1;
  endtask

  // Reference model: instruction class from opcode/funct.
  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h08) return C_JR;
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) return C_R;
        return C_ILL;
      end
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h04, 6'h05: return C_BR;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return C_I;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      default: return C_ILL;
    endcase
  endfunction

  task automatic test_reset();
    #2;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %0d want 0", mem_req); end
    n_vec++; if (alu_src_b !== 2'd0) begin n_err++; $display("FAIL reset_alu_src_b: got %0d want 0", alu_src_b); end
    n_vec++; if (state_o !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_vec++; if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL reset_release_req: got %0d want 1", mem_req); end
    n_vec++; if (alu_src_b !== 2'd1) begin n_err++; $display("FAIL reset_release_srcb: got %0d want 1", alu_src_b); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    exp_retired++;
    $display("add: cycles=%0d retired=%0d", o_cyc, retired);
    n_vec++; if (o_cyc !== 4) begin n_err++; $display("FAIL add_cycles: got %0d want 4", o_cyc); end
    n_vec++; if (o_reg_dst !== 2'd1) begin n_err++; $display("FAIL add_reg_dst: got %0d want 1", o_reg_dst); end
    n_vec++; if (o_exec_alu_op !== 3'd2) begin n_err++; $display("FAIL add_alu_op: got %0d want 2", o_exec_alu_op); end
    n_vec++; if (retired !== 32'd1) begin n_err++; $display("FAIL add_retired: got %0d want 1", retired); end
  endtask

  task automatic test_lw();
    run_instr(6'h23, 6'h00, 1'b0, 3, 3);
    exp_retired++;
    $display("lw: cycles=%0d req_cycles=%0d", o_cyc, o_memreq);
    n_vec++; if (o_cyc !== 11) begin n_err++; $display("FAIL lw_cycles: got %0d want 11", o_cyc); end
    n_vec++; if (o_memreq !== 8) begin n_err++; $display("FAIL lw_req_cycles: got %0d want 8", o_memreq); end
    n_vec++; if (o_wb_sel !== 2'd1) begin n_err++; $display("FAIL lw_wb_sel: got %0d want 1", o_wb_sel); end
    n_vec++; if (o_we !== 0) begin n_err++; $display("FAIL lw_mem_we: got %0d want 0", o_we); end
    n_vec++; if (retired !== exp_retired) begin n_err++; $display("FAIL lw_retired: got %0d want %0d", retired, exp_retired); end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      run_instr(6'h04, 6'h00, (t == 0), 0, 0);
      exp_retired++;
      $display("beq zero=%0d: pc_writes=%0d pc_src=%0d", (t == 0), o_pcw, o_pc_src);
      n_vec++; if (o_pcw !== ((t == 0) ? 2 : 1)) begin n_err++; $display("FAIL beq_pc_write: got %0d want %0d", o_pcw, (t == 0) ? 2 : 1); end
      if (t == 0) begin
        n_vec++; if (o_pc_src !== 2'd1) begin n_err++; $display("FAIL beq_pc_src: got %0d want 1", o_pc_src); end
      end
      n_vec++; if (retired !== exp_retired) begin n_err++; $display("FAIL beq_retired: got %0d want %0d", retired, exp_retired); end
    end
  endtask

  task automatic test_jal();
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);
    exp_retired++;
    $display("jal: cycles=%0d", o_cyc);
    n_vec++; if (o_cyc !== 3) begin n_err++; $display("FAIL jal_cycles: got %0d want 3", o_cyc); end
    n_vec++; if (o_pc_src !== 2'd2 || o_pcw !== 2) begin n_err++; $display("FAIL jal_pc: got src=%0d writes=%0d want src=2 writes=2", o_pc_src, o_pcw); end
    n_vec++; if (o_regw !== 1 || o_reg_dst !== 2'd2 || o_wb_sel !== 2'd2) begin n_err++; $display("FAIL jal_link: got regw=%0d dst=%0d wb=%0d want 1/2/2", o_regw, o_reg_dst, o_wb_sel); end
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    $display("illegal: pulses=%0d", o_ill);
    n_vec++; if (o_ill !== 1) begin n_err++; $display("FAIL ill_pulse: got %0d want 1", o_ill); end
    n_vec++; if (o_regw !== 0 || o_pcw !== 1) begin n_err++; $display("FAIL ill_writes: got regw=%0d pcw=%0d want 0/1", o_regw, o_pcw); end
    n_vec++; if (state_o !== 4'd0 || o_cyc !== 3) begin n_err++; $display("FAIL ill_return: got state=%0d cyc=%0d want 0/3", state_o, o_cyc); end
    n_vec++; if (retired !== exp_retired) begin n_err++; $display("FAIL ill_retired: got %0d want %0d", retired, exp_retired); end
  endtask

  task automatic test_timeout();
    run_instr(6'h2B, 6'h00, 1'b0, 0, NEVER);
    $display("sw timeout: cycles=%0d bus_err=%0d", o_cyc, o_berr);
    n_vec++; if (o_hang !== 1'b0) begin n_err++; $display("FAIL to_hang: got %0d want 0", o_hang); end
    n_vec++; if (o_berr !== 1) begin n_err++; $display("FAIL to_bus_err: got %0d want 1", o_berr); end
    n_vec++; if (o_cyc !== 8) begin n_err++; $display("FAIL to_cycles: got %0d want 8", o_cyc); end
    n_vec++; if (o_we !== 4 || o_memreq !== 5) begin n_err++; $display("FAIL to_req: got we=%0d req=%0d want 4/5", o_we, o_memreq); end
    n_vec++; if (retired !== exp_retired) begin n_err++; $display("FAIL to_retired: got %0d want %0d", retired, exp_retired); end
  endtask

  task automatic test_random();
    logic [5:0] ops[16];
    logic [5:0] fns[9];
    logic [5:0] op, fn;
    logic z;
    int wf, wm, cls, e_cyc, e_pcw, e_regw;
    logic [2:0] e_alu;
    logic [1:0] e_srcb;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
            6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h10};
    fns = '{6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h00, 6'h3F};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 8)];
      z = 1'($urandom);
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      cls = cls_of(op, fn);
      run_instr(op, fn, z, wf, wm);
      e_cyc = wf + 2;
      e_pcw = 1;
      e_regw = 0;
      e_alu = 3'd0;
      e_srcb = 2'd2;
      case (cls)
        C_R:   begin e_cyc += 2; e_regw = 1; e_alu = 3'd2; e_srcb = 2'd0; end
        C_I:   begin
                 e_cyc += 2; e_regw = 1;
                 e_alu = (op == 6'h0A) ? 3'd5 : (op == 6'h0C) ? 3'd3 : (op == 6'h0D) ? 3'd4 :
                         (op == 6'h0F) ? 3'd6 : 3'd0;
               end
        C_BR:  begin e_cyc += 1; e_alu = 3'd1; e_srcb = 2'd0;
                     if ((op == 6'h04) ? z : !z) e_pcw = 2; end
        C_J, C_JR: begin e_cyc += 1; e_pcw = 2; end
        C_JAL: begin e_cyc += 1; e_pcw = 2; e_regw = 1; end
        C_LW:  begin e_cyc += 3 + wm; e_regw = 1; end
        C_SW:  e_cyc += 2 + wm;
        default: e_cyc += 1;
      endcase
      if (cls != C_ILL) exp_retired++;
      $display("rand %0d: op=%02h fn=%02h z=%0d wf=%0d wm=%0d cls=%0d cycles=%0d retired=%0d",
               n, op, fn, z, wf, wm, cls, o_cyc, retired);
      n_vec++; if (o_cyc !== e_cyc) begin n_err++; $display("FAIL rand_cycles: got %0d want %0d", o_cyc, e_cyc); end
      n_vec++; if (o_pcw !== e_pcw) begin n_err++; $display("FAIL rand_pc_write: got %0d want %0d", o_pcw, e_pcw); end
      n_vec++; if (o_regw !== e_regw) begin n_err++; $display("FAIL rand_reg_write: got %0d want %0d", o_regw, e_regw); end
      n_vec++; if (o_ill !== ((cls == C_ILL) ? 1 : 0)) begin n_err++; $display("FAIL rand_illegal: got %0d want %0d", o_ill, (cls == C_ILL) ? 1 : 0); end
      n_vec++; if (o_dec_srcb !== 2'd3) begin n_err++; $display("FAIL rand_decode_srcb: got %0d want 3", o_dec_srcb); end
      n_vec++; if (retired !== exp_retired) begin n_err++; $display("FAIL rand_retired: got %0d want %0d", retired, exp_retired); end
      if (cls == C_R || cls == C_I || cls == C_BR || cls == C_LW || cls == C_SW) begin
        n_vec++; if (o_exec_alu_op !== e_alu || o_exec_srcb !== e_srcb) begin n_err++; $display("FAIL rand_exec: got op=%0d srcb=%0d want op=%0d srcb=%0d", o_exec_alu_op, o_exec_srcb, e_alu, e_srcb); end
      end
      if (cls == C_SW) begin
        n_vec++; if (o_we !== wm + 1) begin n_err++; $display("FAIL rand_mem_we: got %0d want %0d", o_we, wm + 1); end
      end
      if (e_regw == 1) begin
        n_vec++;
        if (o_reg_dst !== ((cls == C_R) ? 2'd1 : (cls == C_JAL) ? 2'd2 : 2'd0) ||
            o_wb_sel !== ((cls == C_LW) ? 2'd1 : (cls == C_JAL) ? 2'd2 : 2'd0)) begin
          n_err++; $display("FAIL rand_wb_fields: got dst=%0d wb=%0d for cls=%0d", o_reg_dst, o_wb_sel, cls);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL arst_pre_req: got %0d want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    $display("async reset mid-fetch: mem_req=%0d state=%0d retired=%0d", mem_req, state_o, retired);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL arst_req_drop: got %0d want 0", mem_req); end
    n_vec++; if (retired !== 32'd0) begin n_err++; $display("FAIL arst_retired: got %0d want 0", retired); end
    exp_retired = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (state_o !== 4'd0 || mem_req !== 1'b1) begin n_err++; $display("FAIL arst_release: got state=%0d req=%0d want 0/1", state_o, mem_req); end
    @(posedge clk);
    #1;
    run_instr(6'h00, 6'h22, 1'b0, 1, 0);
    exp_retired++;
    n_vec++; if (retired !== exp_retired || o_cyc !== 5) begin n_err++; $display("FAIL arst_after_sub: got retired=%0d cyc=%0d want %0d/5", retired, o_cyc, exp_retired); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_jal();
    test_illegal();
    test_timeout();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
